// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_t : 3-bit sequencer state encoding (0..5 used, 6/7 unreachable)
//   DEF_*       : default cycle counts for the sequencer delay phases
package rst_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_CLK_EN    = 3'd2,
        S_DDR_REL   = 3'd3,
        S_RUN       = 3'd4,
        S_SOFT_RST  = 3'd5
    } seq_state_t;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_CLK_EN_CYCLES      = 16;
    localparam int unsigned DEF_DDR_TO_CORE_CYCLES = 256;
    localparam int unsigned DEF_SOFT_RST_CYCLES    = 32;
    localparam int unsigned DEF_CNT_W              = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronised output (two-cycle latency)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / reset sequencer for the Briey SoC top level.
// Waits for a stable (synchronised) PLL lock, enables the DDR3 memory clock,
// then releases the DDR3 reset and finally the core/SPI resets. A debug
// soft-reset request pulses only the core/SPI reset.
//   clk50        : 50 MHz board clock
//   cpu_reset    : asynchronous active-low reset
//   pll_lock     : PLL lock, asynchronous to clk50
//   soft_rst_req : single-cycle soft-reset request (clk50 domain)
//   pll_clk_en   : DDR3 memory clock enable
//   ddr_rst_n    : DDR3 controller reset, active-low
//   core_rst_n   : core reset, active-low
//   spi_resetn   : SPI reset, active-low, identical to core_rst_n
//   seq_state    : current state encoding (debug)
// Build option: RSTSEQ_LOCK_MON_EN -- lock loss after the memory clock is
// enabled restarts the whole sequence from lock wait.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned CLK_EN_CYCLES      = DEF_CLK_EN_CYCLES,
    parameter int unsigned DDR_TO_CORE_CYCLES = DEF_DDR_TO_CORE_CYCLES,
    parameter int unsigned SOFT_RST_CYCLES    = DEF_SOFT_RST_CYCLES,
    parameter int unsigned CNT_W              = DEF_CNT_W
) (
    input  logic       clk50,
    input  logic       cpu_reset,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       pll_clk_en,
    output logic       ddr_rst_n,
    output logic       core_rst_n,
    output logic       spi_resetn,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLK_EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DDR_LAST  = CNT_W'(DDR_TO_CORE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_RST_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_s;
    logic             clk_en_d, ddr_rel_d, core_rel_d;

    sync_2ff u_lock_sync (
        .clk   (clk50),
        .rst_n (cpu_reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Counter starts at 0 on entry to a delay state, so "== N-1" exits after exactly N cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
            end
            S_WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_CLK_EN;
                    cnt_d   = '0;
                end
            end
            S_CLK_EN: begin
                if (cnt_q == CLK_LAST) begin
                    state_d = S_DDR_REL;
                    cnt_d   = '0;
                end
            end
            S_DDR_REL: begin
                if (cnt_q == DDR_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (soft_rst_req) begin
                    state_d = S_SOFT_RST;
                end
            end
            S_SOFT_RST: begin
                if (cnt_q == SOFT_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef RSTSEQ_LOCK_MON_EN
        // Lock loss overrides everything else, including a soft-reset request.
        if (!lock_s && (state_q inside {S_CLK_EN, S_DDR_REL, S_RUN, S_SOFT_RST})) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
        end
`endif

        // Outputs decoded from the next state so they change together with seq_state.
        clk_en_d   = state_d inside {S_CLK_EN, S_DDR_REL, S_RUN, S_SOFT_RST};
        ddr_rel_d  = state_d inside {S_DDR_REL, S_RUN, S_SOFT_RST};
        core_rel_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk50 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pll_clk_en <= 1'b0;
            ddr_rst_n  <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pll_clk_en <= clk_en_d;
            ddr_rst_n  <= ddr_rel_d;
            core_rst_n <= core_rel_d;
        end
    end

    assign spi_resetn = core_rst_n;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timestamp-based reference model
// compared every cycle, plus literal timing expectations for directed cases.
module tb_reset_sequencer;

    localparam int LOCK = 1024;
    localparam int CLKN = 16;
    localparam int DDRN = 256;
    localparam int SOFTN = 32;

    logic       clk50 = 1'b0;
    logic       cpu_reset;
    logic       pll_lock = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       pll_clk_en, ddr_rst_n, core_rst_n, spi_resetn;
    logic [2:0] seq_state;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int rel_edges = 0;

    always #10 clk50 = ~clk50;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES (LOCK),
        .CLK_EN_CYCLES      (CLKN),
        .DDR_TO_CORE_CYCLES (DDRN),
        .SOFT_RST_CYCLES    (SOFTN),
        .CNT_W              (16)
    ) dut (
        .clk50        (clk50),
        .cpu_reset    (cpu_reset),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .pll_clk_en   (pll_clk_en),
        .ddr_rst_n    (ddr_rst_n),
        .core_rst_n   (core_rst_n),
        .spi_resetn   (spi_resetn),
        .seq_state    (seq_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Edges since reset release (first edge after release is 1).
    always @(posedge clk50 or negedge cpu_reset) begin
        if (!cpu_reset) rel_edges = 0;
        else            rel_edges = rel_edges + 1;
    end

    // Reference model: phases expressed as timestamps of when they began.
    int   m_state = 0, m_run = 0, m_t_clk = 0, m_t_soft = 0, m_edge = 0;
    logic m_hist[$];

    always @(posedge clk50 or negedge cpu_reset) begin : model
        int   prev, e;
        logic ls;
        if (!cpu_reset) begin
            m_state = 0;
            m_run   = 0;
            m_edge  = 0;
            m_hist.delete();
        end else begin
            m_edge = m_edge + 1;
            m_hist.push_back(pll_lock);
            if (m_hist.size() > 3) void'(m_hist.pop_front());
            // lock value seen by the sequencer = pll_lock sampled two edges earlier
            ls   = (m_hist.size() == 3) ? m_hist[0] : 1'b0;
            prev = m_state;
            case (prev)
                0: begin
                    m_state = 1;
                    m_run   = 0;
                end
                1: begin
                    m_run = ls ? m_run + 1 : 0;
                    if (m_run == LOCK) begin
                        m_state = 2;
                        m_t_clk = m_edge;
                    end
                end
                2, 3: begin
                    e = m_edge - m_t_clk;
                    m_state = (e < CLKN) ? 2 : (e < CLKN + DDRN) ? 3 : 4;
                end
                4: begin
                    if (soft_rst_req) begin
                        m_state  = 5;
                        m_t_soft = m_edge;
                    end
                end
                default: begin
                    if (m_edge - m_t_soft >= SOFTN) m_state = 4;
                end
            endcase
`ifdef RSTSEQ_LOCK_MON_EN
            if (prev >= 2 && !ls) begin
                m_state = 1;
                m_run   = 0;
            end
`endif
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk50) begin
        if (chk_en) begin
            check("seq_state",  32'(seq_state),  32'(m_state));
            check("pll_clk_en", 32'(pll_clk_en), 32'(m_state >= 2));
            check("ddr_rst_n",  32'(ddr_rst_n),  32'(m_state >= 3));
            check("core_rst_n", 32'(core_rst_n), 32'(m_state == 4));
            check("spi_resetn", 32'(spi_resetn), 32'(m_state == 4));
        end
    end

    task automatic apply_reset(input int lock_at);
        @(posedge clk50); #1;
        cpu_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == lock_at) pll_lock = 1'b1;
            @(posedge clk50); #1;
        end
        cpu_reset = 1'b1;
    endtask

    // Waits for an output to go high; reports the edge number it appeared after.
    task automatic run_until(input int which, input int budget, input bit soft_noise, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk50); #1;
            case (which)
                0:       s = pll_clk_en;
                1:       s = ddr_rst_n;
                default: s = core_rst_n;
            endcase
            if (s === 1'b1) begin
                at = rel_edges;
                soft_rst_req = 1'b0;
                return;
            end
            soft_rst_req = soft_noise ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
        soft_rst_req = 1'b0;
        check("wait_timeout", 32'(which), 32'hFFFF_FFFF);
    endtask

    initial begin
        int at, low;
        cpu_reset = 1'b0;
        #1 chk_en = 1'b1;

        // Boot with lock arriving during reset
        apply_reset(5);
        run_until(0, 3000, 1'b0, at);  check("boot_clk_en_edge", 32'(at), 32'd1026);
        run_until(1, 100, 1'b0, at);   check("boot_ddr_edge",    32'(at), 32'd1042);
        run_until(2, 400, 1'b0, at);   check("boot_core_edge",   32'(at), 32'd1298);

        // Soft reset: exactly 32 low cycles; a second request inside is ignored
        repeat (5) @(posedge clk50);
        #1 soft_rst_req = 1'b1;
        @(posedge clk50); #1 soft_rst_req = 1'b0;
        low = 0;
        while (core_rst_n === 1'b0 && low < 100) begin
            low++;
            soft_rst_req = (low == 10);
            @(posedge clk50); #1;
        end
        soft_rst_req = 1'b0;
        check("soft_low_cycles", 32'(low), 32'd32);
        check("soft_ddr_held",   32'(ddr_rst_n),  32'd1);
        check("soft_clk_held",   32'(pll_clk_en), 32'd1);

        // Lock loss while running
        repeat (4) @(posedge clk50);
        #1 pll_lock = 1'b0;
        @(posedge clk50); #1 pll_lock = 1'b1;
        @(posedge clk50); #1;
        @(posedge clk50); #1;
`ifdef RSTSEQ_LOCK_MON_EN
        check("lockmon_state", 32'(seq_state),  32'd1);
        check("lockmon_clk",   32'(pll_clk_en), 32'd0);
        check("lockmon_core",  32'(core_rst_n), 32'd0);
`else
        check("lockmon_state", 32'(seq_state),  32'd4);
        check("lockmon_clk",   32'(pll_clk_en), 32'd1);
        check("lockmon_core",  32'(core_rst_n), 32'd1);
`endif

        // Lock glitch at stable count 500
        pll_lock = 1'b0;
        apply_reset(0);
        while (rel_edges < 502) begin @(posedge clk50); #1; end
        pll_lock = 1'b0;
        @(posedge clk50); #1 pll_lock = 1'b1;
        run_until(0, 3000, 1'b0, at);  check("glitch_clk_en_edge", 32'(at), 32'd1529);
        run_until(2, 400, 1'b0, at);   check("glitch_core_edge",   32'(at), 32'd1801);

        // Reset asserted during DDR release phase
        apply_reset(0);
        run_until(1, 3000, 1'b0, at);
        repeat (20) @(posedge clk50);
        #5 cpu_reset = 1'b0;
        #1;
        check("async_clk_en", 32'(pll_clk_en), 32'd0);
        check("async_ddr",    32'(ddr_rst_n),  32'd0);
        check("async_core",   32'(core_rst_n), 32'd0);
        check("async_spi",    32'(spi_resetn), 32'd0);
        check("async_state",  32'(seq_state),  32'd0);
        repeat (5) @(posedge clk50);
        #1 cpu_reset = 1'b1;
        run_until(2, 3000, 1'b0, at);  check("restart_core_edge", 32'(at), 32'd1298);

        // Soft requests during lock wait are ignored
        apply_reset(2);
        run_until(0, 3000, 1'b1, at);  check("noise_clk_en_edge", 32'(at), 32'd1026);

        // Randomised runs: lock noise early, rare glitches later, random soft requests
        for (int it = 0; it < 3; it++) begin
            apply_reset(int'($urandom_range(0, 9)));
            for (int c = 0; c < 2500; c++) begin
                @(posedge clk50); #1;
                if (rel_edges < 300) pll_lock = ($urandom_range(0, 19) != 0);
                else                 pll_lock = ($urandom_range(0, 2999) != 0);
                soft_rst_req = ($urandom_range(0, 49) == 0);
            end
            soft_rst_req = 1'b0;
            pll_lock = 1'b1;
        end

        @(posedge clk50); #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
